pid_wb_master: RTL and testbench

- Wishbone classic single-transfer initiator, the master-side counterpart of the pid block's Wishbone slave port.
- Converts one command from a valid/ready request port into one Wishbone cycle to the pid slave (or any classic slave).
- Returns a single-cycle response pulse carrying read data or a timeout error.
- Replaces the ad hoc divider-driven strobe generation feeding pid with a protocol-correct, bounded-latency driver.

---
 rtl/pid_wb_pkg.sv | 21 ++
 rtl/pid_wb_master_if.sv | 38 +++
 rtl/wb_timeout_cnt.sv | 37 +++
 rtl/pid_wb_master.sv | 122 ++++++++++++
 tb/tb_pid_wb_master.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pid_wb_pkg.sv
// Shared definitions for the pid Wishbone initiator: bus widths, FSM states
// and the pid slave register map.
package pid_wb_pkg;

  localparam int unsigned WbNbDefault    = 32;
  localparam int unsigned AdrWbNbDefault = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } wb_state_e;

  localparam logic [7:0] AdrKp = 8'h00;
  localparam logic [7:0] AdrKi = 8'h04;
  localparam logic [7:0] AdrKd = 8'h08;
  localparam logic [7:0] AdrSp = 8'h0C;
  localparam logic [7:0] AdrPv = 8'h10;
  localparam logic [7:0] AdrUn = 8'h14;

endpackage

// File: rtl/pid_wb_master_if.sv
// Request/response port plus Wishbone classic bus of the pid initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface pid_wb_master_if #(
  parameter int unsigned WB_NB     = 32,
  parameter int unsigned ADR_WB_NB = 32
) ();

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_we;
  logic [ADR_WB_NB-1:0] i_req_adr;
  logic [WB_NB-1:0]     i_req_data;

  logic                 o_rsp_valid;
  logic [WB_NB-1:0]     o_rsp_data;
  logic                 o_rsp_err;

  logic                 o_wb_cyc;
  logic                 o_wb_stb;
  logic                 o_wb_we;
  logic [ADR_WB_NB-1:0] o_wb_adr;
  logic [WB_NB-1:0]     o_wb_data;
  logic                 i_wb_ack;
  logic [WB_NB-1:0]     i_wb_data;

  modport master (
    input  i_req_valid, i_req_we, i_req_adr, i_req_data, i_wb_ack, i_wb_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_adr, i_req_data, i_wb_ack, i_wb_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Clear/enable saturating counter; tc_o flags the last cycle before timeout.
module wb_timeout_cnt #(
  parameter int unsigned Max  = 255,
  parameter int unsigned CntW = $clog2(Max + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(Max);
  localparam logic [CntW-1:0] CntTc  = CntW'(Max - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntTc);

endmodule

// File: rtl/pid_wb_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes
// one CYC/STB cycle, answered by a one-cycle response pulse or a timeout error.
module pid_wb_master
  import pid_wb_pkg::*;
#(
  parameter int unsigned WB_NB       = WbNbDefault,
  parameter int unsigned ADR_WB_NB   = AdrWbNbDefault,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pid_wb_master_if.master     bus,
  output logic                o_busy
);

  wb_state_e            state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADR_WB_NB-1:0] adr_q, adr_d;
  logic [WB_NB-1:0]     wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WB_NB-1:0]     rsp_data_q, rsp_data_d;
  logic                 cnt_clr, cnt_en, cnt_tc;

  wb_timeout_cnt #(
    .Max  (TIMEOUT_CYC),
    .CntW ($clog2(TIMEOUT_CYC + 1))
  ) u_timeout_cnt (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid) begin
          we_d    = bus.i_req_we;
          adr_d   = bus.i_req_adr;
          wdata_d = bus.i_req_data;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        // ACK takes priority over a coincident timeout.
        if (bus.i_wb_ack) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? '0 : bus.i_wb_data;
          state_d     = StResp;
        end else if (cnt_tc) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = StResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Ready is masked by reset so nothing is accepted while reset is asserted.
  assign bus.o_req_ready = (state_q == StIdle) && !i_rst;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_wb_cyc    = cyc_q;
  assign bus.o_wb_stb    = cyc_q;
  assign bus.o_wb_we     = we_q;
  assign bus.o_wb_adr    = adr_q;
  assign bus.o_wb_data   = wdata_q;
  assign o_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_pid_wb_master.sv
// Randomized self-checking bench for pid_wb_master with a transaction-level
// reference model of acceptance, STB duration, response and timeout.
module tb_pid_wb_master;
  import pid_wb_pkg::*;

  localparam int unsigned TimeoutCyc = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pid_wb_master_if #(.WB_NB(32), .ADR_WB_NB(32)) bus ();

  pid_wb_master #(
    .WB_NB       (32),
    .ADR_WB_NB   (32),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a slave acking on BUS edge `delay` (0 = never) yields
  // min(delay, TimeoutCyc) STB cycles; beyond the limit it is an error.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         input int unsigned delay, input logic [31:0] rdata);
    logic        exp_err;
    int unsigned exp_n;
    logic [31:0] exp_data;
    int unsigned stb_n;
    bit          done;
    exp_err  = (delay == 0) || (delay > TimeoutCyc);
    exp_n    = exp_err ? TimeoutCyc : delay;
    exp_data = (exp_err || we) ? 32'h0 : rdata;

    @(negedge clk);
    check_eq("ready_idle", bus.o_req_ready, 1'b1);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_adr   = adr;
    bus.i_req_data  = wdata;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = $urandom_range(0, 1);
    bus.i_req_adr   = $urandom;
    bus.i_req_data  = $urandom;
    stb_n = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!bus.o_wb_stb) begin
        done = 1'b1;
      end else begin
        stb_n++;
        check_eq("bus_hold", {bus.o_wb_cyc, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_data,
                              bus.o_rsp_valid, bus.o_req_ready},
                 {1'b1, we, adr, wdata, 1'b0, 1'b0});
        bus.i_wb_ack  = (stb_n == delay);
        bus.i_wb_data = bus.i_wb_ack ? rdata : $urandom;
        @(posedge clk);
        #1;
        bus.i_wb_ack  = 1'b0;
      end
    end
    check_eq("stb_drop", done, 1'b1);
    check_eq("stb_cycles", 32'(stb_n), 32'(exp_n));
    check_eq("rsp", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data, bus.o_req_ready,
                     busy, bus.o_wb_cyc},
             {1'b1, exp_err, exp_data, 1'b0, 1'b1, 1'b0});
    if (!exp_err) check_eq("we_clr", bus.o_wb_we, 1'b0);
    @(negedge clk);
    check_eq("rsp_end", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data, bus.o_req_ready, busy},
             {1'b0, 1'b0, exp_data, 1'b1, 1'b0});
  endtask

  task automatic spurious_ack();
    @(negedge clk);
    bus.i_wb_ack  = 1'b1;
    bus.i_wb_data = $urandom;
    @(posedge clk);
    #1 bus.i_wb_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack", {busy, bus.o_rsp_valid, bus.o_wb_stb, bus.o_req_ready}, 4'b0001);
  endtask

  task automatic back_to_back();
    logic [31:0] b_adr [3];
    logic [31:0] b_dat [3];
    int acc_n, rsp_n, last_acc;
    bit accepted;
    b_adr[0] = {24'h0, AdrKp};
    b_adr[1] = {24'h0, AdrKi};
    b_adr[2] = {24'h0, AdrKd};
    for (int i = 0; i < 3; i++) b_dat[i] = $urandom;
    acc_n = 0;
    rsp_n = 0;
    last_acc = 0;
    @(negedge clk);
    // ACK held high throughout: it must only matter while in BUS.
    bus.i_wb_ack    = 1'b1;
    bus.i_wb_data   = $urandom;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_adr   = b_adr[0];
    bus.i_req_data  = b_dat[0];
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.o_rsp_valid) begin
        rsp_n++;
        check_eq("b2b_rsp", {bus.o_rsp_err, bus.o_rsp_data}, 33'h0);
      end
      if (bus.o_wb_stb && acc_n > 0)
        check_eq("b2b_adr", {bus.o_wb_adr, bus.o_wb_data}, {b_adr[acc_n-1], b_dat[acc_n-1]});
      accepted = bus.i_req_valid && bus.o_req_ready;
      if (accepted) begin
        if (acc_n > 0) check_eq("b2b_gap", 32'(c - last_acc), 32'd3);
        last_acc = c;
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (accepted) begin
        if (acc_n == 3) begin
          bus.i_req_valid = 1'b0;
        end else begin
          bus.i_req_adr  = b_adr[acc_n];
          bus.i_req_data = b_dat[acc_n];
        end
      end
    end
    bus.i_wb_ack = 1'b0;
    check_eq("b2b_acc", 32'(acc_n), 32'd3);
    check_eq("b2b_pulses", 32'(rsp_n), 32'd3);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_adr   = {24'h0, AdrSp};
    bus.i_req_data  = $urandom;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    check_eq("rm_bus1", bus.o_wb_stb, 1'b1);
    @(negedge clk);
    check_eq("rm_bus2", bus.o_wb_stb, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rm_drop", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_rsp_valid, bus.o_req_ready, busy},
             5'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rm_after", {bus.o_req_ready, bus.o_rsp_valid, bus.o_wb_stb}, 3'b100);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_adr   = '0;
    bus.i_req_data  = '0;
    bus.i_wb_ack    = 1'b0;
    bus.i_wb_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.o_req_ready, 1'b0);
    check_eq("rst_bus", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_adr, bus.o_wb_data},
             '0);
    check_eq("rst_rsp", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data, busy}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", bus.o_req_ready, 1'b1);

    run_txn(1'b1, {24'h0, AdrKi}, 32'h0001_0000, 1, 32'hA5A5_A5A5);
    run_txn(1'b0, {24'h0, AdrUn}, 32'h0, 4, 32'hDEAD_BEEF);
    run_txn(1'b0, {24'h0, AdrPv}, 32'h0, 0, 32'h0);
    run_txn(1'b0, {24'h0, AdrPv}, 32'h0, TimeoutCyc, 32'h1234_5678);
    run_txn(1'b1, {24'h0, AdrKd}, 32'h0BAD_F00D, TimeoutCyc + 1, 32'h0);
    spurious_ack();
    back_to_back();
    for (int i = 0; i < 25; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 11), $urandom);
      if ($urandom_range(0, 3) == 0) spurious_ack();
    end
    reset_mid();
    run_txn(1'b0, {24'h0, AdrKp}, 32'h0, 2, 32'hCAFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
